prog_loader: RTL and testbench

//  Upstream sequencer for the 9-bit core: on req, streams a byte image into data memory.

---
 rtl/loader_pkg.sv | 8 +
 rtl/loader_timer.sv | 25 ++
 rtl/prog_loader.sv | 122 ++++++++++++
 tb/tb_prog_loader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} ldr_state_t;

    localparam int unsigned TIMER_W = 16;

endpackage

// File: rtl/loader_timer.sv
// RUN-phase cycle counter: synchronous clear, count enable, terminal-count flag.
module loader_timer
    import loader_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    output logic [TIMER_W-1:0] count,
    output logic               tc
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Streams a byte image into data memory, then runs the core until done or timeout.
// Optional LOADER_CSUM_EN adds a load_csum port carrying the XOR of the loaded bytes.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned LOAD_BASE = 0,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dat,
    output logic          core_reset,
    input  logic          core_done,
    output logic          done,
    output logic          timed_out,
    output logic [AW:0]   load_count
`ifdef LOADER_CSUM_EN
    ,
    output logic [7:0]    load_csum
`endif
);

    localparam logic [AW:0] LAST_BEFORE_FULL = {1'b0, {AW{1'b1}}};

    ldr_state_t         state;
    logic [AW-1:0]      addr;
    logic               beat;
    logic [TIMER_W-1:0] run_cycles;
    logic               timer_tc;

    assign in_ready  = (state == LOAD);
    assign beat      = in_valid & in_ready;
    assign mem_wr_en = beat;
    assign mem_addr  = addr;
    assign mem_dat   = in_data;

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state != RUN),
        .en    (state == RUN),
        .count (run_cycles),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= AW'(LOAD_BASE);
            core_reset <= 1'b1;
            done       <= 1'b0;
            timed_out  <= 1'b0;
            load_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state      <= LOAD;
                        addr       <= AW'(LOAD_BASE);
                        load_count <= '0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        addr       <= addr + 1'b1;
                        load_count <= load_count + 1'b1;
                        // Leave on the last byte or once every address has been written.
                        if (in_last || load_count == LAST_BEFORE_FULL) begin
                            state      <= RUN;
                            core_reset <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // First RUN cycle ignores core_done while the core's PC settles.
                    if (core_done && run_cycles != '0) begin
                        state      <= FIN;
                        done       <= 1'b1;
                        timed_out  <= 1'b0;
                        core_reset <= 1'b1;
                    end else if (timer_tc) begin
                        state      <= FIN;
                        done       <= 1'b1;
                        timed_out  <= 1'b1;
                        core_reset <= 1'b1;
                    end
                end
                FIN: begin
                    if (!req) begin
                        state     <= IDLE;
                        done      <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOADER_CSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            load_csum <= '0;
        end else if (state == IDLE && req) begin
            load_csum <= '0;
        end else if (beat) begin
            load_csum <= load_csum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a wide instance (AW=8, base 0) and a small wrapping one (AW=2, base 3).
module tb_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       req, in_valid, in_last, core_done;
    logic [7:0] in_data;
    logic       in_ready, mem_wr_en, core_reset, done, timed_out;
    logic [7:0] mem_addr, mem_dat;
    logic [8:0] load_count;

    logic       s_req, s_in_valid, s_in_last, s_core_done;
    logic [7:0] s_in_data;
    logic       s_in_ready, s_mem_wr_en, s_core_reset, s_done, s_timed_out;
    logic [1:0] s_mem_addr;
    logic [7:0] s_mem_dat;
    logic [2:0] s_load_count;

`ifdef LOADER_CSUM_EN
    logic [7:0] load_csum, s_load_csum;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    logic [9:0]  s_exp_q[$];
    logic [7:0]  exp_addr;
    logic [1:0]  s_exp_addr;
    logic [15:0] exp_w;
    logic [9:0]  s_exp_w;

    prog_loader #(
        .AW        (8),
        .LOAD_BASE (0),
        .TIMEOUT   (16)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_dat    (mem_dat),
        .core_reset (core_reset),
        .core_done  (core_done),
        .done       (done),
        .timed_out  (timed_out),
        .load_count (load_count)
`ifdef LOADER_CSUM_EN
        ,
        .load_csum  (load_csum)
`endif
    );

    prog_loader #(
        .AW        (2),
        .LOAD_BASE (3),
        .TIMEOUT   (8)
    ) u_small (
        .clk        (clk),
        .reset      (reset),
        .req        (s_req),
        .in_valid   (s_in_valid),
        .in_data    (s_in_data),
        .in_last    (s_in_last),
        .in_ready   (s_in_ready),
        .mem_wr_en  (s_mem_wr_en),
        .mem_addr   (s_mem_addr),
        .mem_dat    (s_mem_dat),
        .core_reset (s_core_reset),
        .core_done  (s_core_done),
        .done       (s_done),
        .timed_out  (s_timed_out),
        .load_count (s_load_count)
`ifdef LOADER_CSUM_EN
        ,
        .load_csum  (s_load_csum)
`endif
    );

    // Write scoreboards: every DUT write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%0h dat=%0h, required no write",
                         mem_addr, mem_dat);
            end else begin
                exp_w = exp_q.pop_front();
                if ({mem_addr, mem_dat} !== exp_w) begin
                    errors++;
                    $display("FAIL wr_data: got addr=%0h dat=%0h, required addr=%0h dat=%0h",
                             mem_addr, mem_dat, exp_w[15:8], exp_w[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (s_mem_wr_en === 1'b1) begin
            checks++;
            if (s_exp_q.size() == 0) begin
                errors++;
                $display("FAIL s_wr_unexpected: got addr=%0h dat=%0h, required no write",
                         s_mem_addr, s_mem_dat);
            end else begin
                s_exp_w = s_exp_q.pop_front();
                if ({s_mem_addr, s_mem_dat} !== s_exp_w) begin
                    errors++;
                    $display("FAIL s_wr_data: got addr=%0h dat=%0h, required addr=%0h dat=%0h",
                             s_mem_addr, s_mem_dat, s_exp_w[9:8], s_exp_w[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        exp_q.push_back({exp_addr, d});
        exp_addr = exp_addr + 8'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic s_send(input logic [7:0] d);
        s_in_valid = 1'b1;
        s_in_data  = d;
        s_exp_q.push_back({s_exp_addr, d});
        s_exp_addr = s_exp_addr + 2'd1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
    endtask

    // Request a load while offering a byte that must not be taken in IDLE.
    task automatic start_load();
        req      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(posedge clk); #1;
        req      = 1'b0;
        in_valid = 1'b0;
        exp_addr = 8'd0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 0; in_valid = 0; in_last = 0; in_data = 0; core_done = 0;
        s_req = 0; s_in_valid = 0; s_in_last = 0; s_in_data = 0; s_core_done = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b required 0", mem_wr_en); end
        checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL rst_addr: got %0h required 0", mem_addr); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset: got %b required 1", core_reset); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rst_timed_out: got %b required 0", timed_out); end
        checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", load_count); end
        checks++; if (s_mem_addr !== 2'd3) begin errors++; $display("FAIL rst_s_addr: got %0d required 3", s_mem_addr); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_image();
        start_load();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        in_valid = 1'b1; in_data = 8'h44; in_last = 1'b1;
        exp_q.push_back({exp_addr, 8'h44});
        exp_addr = exp_addr + 8'd1;
        @(negedge clk);
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL img_hold: got %b required 1", core_reset); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL img_release: got %b required 0", core_reset); end
        checks++; if (load_count !== 9'd4) begin errors++; $display("FAIL img_count: got %0d required 4", load_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL img_ready: got %b required 0", in_ready); end
`ifdef LOADER_CSUM_EN
        checks++; if (load_csum !== 8'h44) begin errors++; $display("FAIL img_csum: got %0h required 44", load_csum); end
`endif
    endtask

    // Entered at the negedge of RUN cycle 1.
    task automatic test_done_filter();
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flt_early: got done=%b required 0", done); end
        repeat (8) @(posedge clk);
        #1;
        core_done = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flt_c10: got done=%b required 0", done); end
        @(posedge clk); #1;
        core_done = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL flt_done: got %b required 1", done); end
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL flt_to: got %b required 0", timed_out); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL flt_core_reset: got %b required 1", core_reset); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flt_idle: got done=%b required 0", done); end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        int n;
        start_load();
        send(8'h5A, 1'b0);
        @(posedge clk); #1;
        send(8'hA5, 1'b0);
        @(posedge clk); #1;
        send(8'h3C, 1'b1);
        @(negedge clk);
        checks++; if (load_count !== 9'd3) begin errors++; $display("FAIL gap_count: got %0d required 3", load_count); end
        req = 1'b1;
        core_done = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done: got %b required 1 within 20 cycles", done); end
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL gap_to: got %b required 0", timed_out); end
        core_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_fin_hold: got %b required 1", done); end
        req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_idle: got %b required 0", done); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        start_load();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL mid_count: got %0d required 0", load_count); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL mid_core_reset: got %b required 1", core_reset); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b required 0", in_ready); end
        checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL mid_addr: got %0h required 0", mem_addr); end
`ifdef LOADER_CSUM_EN
        checks++; if (load_csum !== 8'h00) begin errors++; $display("FAIL mid_csum: got %0h required 0", load_csum); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_timeout();
        s_req = 1'b1;
        @(posedge clk); #1;
        s_req = 1'b0;
        s_exp_addr = 2'd3;
        s_send(8'h10);
        s_send(8'h20);
        s_send(8'h30);
        s_send(8'h40);
        // RUN cycle 1: a fifth byte is offered but must be refused.
        s_in_valid = 1'b1;
        s_in_data  = 8'h50;
        @(negedge clk);
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL wrap_ready: got %b required 0", s_in_ready); end
        checks++; if (s_load_count !== 3'd4) begin errors++; $display("FAIL wrap_count: got %0d required 4", s_load_count); end
        checks++; if (s_core_reset !== 1'b0) begin errors++; $display("FAIL wrap_run: got %b required 0", s_core_reset); end
        checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL to_c1: got done=%b required 0", s_done); end
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                checks++;
                if (s_done !== 1'b0) begin errors++; $display("FAIL to_c%0d: got done=%b required 0", c, s_done); end
            end else begin
                checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL to_done: got %b required 1", s_done); end
                checks++; if (s_timed_out !== 1'b1) begin errors++; $display("FAIL to_flag: got %b required 1", s_timed_out); end
                checks++; if (s_core_reset !== 1'b1) begin errors++; $display("FAIL to_core_reset: got %b required 1", s_core_reset); end
            end
        end
        s_in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL to_idle: got %b required 0", s_done); end
    endtask

    initial begin
        test_reset();
        test_image();
        test_done_filter();
        test_gaps();
        test_reset_mid_load();
        test_wrap_timeout();
        @(posedge clk); #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wr_missing: got %0d pending required 0", exp_q.size()); end
        checks++; if (s_exp_q.size() != 0) begin errors++; $display("FAIL s_wr_missing: got %0d pending required 0", s_exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
